// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel for pwm_ramp_ctrl: valid/ready handshake carrying a
// stop flag or a period / target / ramp-step / hold configuration.
interface pwm_ramp_ctrl_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HOLD_W = 16
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_stop;
  logic [CNT_W-1:0]  cmd_arr;
  logic [CNT_W-1:0]  cmd_ccr;
  logic [CNT_W-1:0]  cmd_step;
  logic [HOLD_W-1:0] cmd_hold;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_stop,
    output cmd_arr,
    output cmd_ccr,
    output cmd_step,
    output cmd_hold,
    input  cmd_ready
  );

  // Controller side
  modport slave (
    input  cmd_valid,
    input  cmd_stop,
    input  cmd_arr,
    input  cmd_ccr,
    input  cmd_step,
    input  cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: drives cnt_en / counter_arr / counter_ccr of a PWM
// generator. Compare value ramps toward a clamped target in fixed steps,
// one step every (hold+1) periods; all configuration changes land on a
// period boundary so the generator never sees a mid-period update.
module pwm_ramp_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HOLD_W = 16
) (
  input  logic             Clk50M,
  input  logic             Rst,
  pwm_ramp_ctrl_if.slave   cmd,
  output logic             cnt_en,
  output logic [CNT_W-1:0] counter_arr,
  output logic [CNT_W-1:0] counter_ccr,
  output logic             period_end,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    STEADY,
    STOP_WAIT
  } state_t;

  state_t            state_q,       state_d;
  logic              cnt_en_q,      cnt_en_d;
  logic [CNT_W-1:0]  counter_arr_q, counter_arr_d;
  logic [CNT_W-1:0]  counter_ccr_q, counter_ccr_d;
  logic [CNT_W-1:0]  period_cnt_q,  period_cnt_d;
  logic [CNT_W-1:0]  arr_pend_q,    arr_pend_d;
  logic [CNT_W:0]    tgt_q,         tgt_d;
  logic [CNT_W-1:0]  step_q,        step_d;
  logic [HOLD_W-1:0] hold_q,        hold_d;
  logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic              cmd_ready_q,   cmd_ready_d;
  logic              busy_q,        busy_d;
  logic              done_q,        done_d;

  logic              accept;
  logic              pend;
  logic [CNT_W:0]    arr_plus1;
  logic [CNT_W:0]    cmd_ccr_ext;
  logic [CNT_W:0]    tgt_new;
  logic [CNT_W:0]    ccr_ext;
  logic [CNT_W:0]    step_ext;
  logic [CNT_W:0]    ramp_sum;
  logic [CNT_W:0]    ramp_gap;
  logic [CNT_W:0]    ccr_next;

  assign accept     = cmd.cmd_valid && cmd_ready_q;
  assign pend       = cnt_en_q && (period_cnt_q == counter_arr_q);

  assign cmd.cmd_ready = cmd_ready_q;
  assign cnt_en        = cnt_en_q;
  assign counter_arr   = counter_arr_q;
  assign counter_ccr   = counter_ccr_q;
  assign period_end    = pend;
  assign busy          = busy_q;
  assign done          = done_q;

  // Target clamp: min(cmd_ccr, cmd_arr+1) at CNT_W+1 bits (arr+1 = 100% duty)
  always_comb begin
    arr_plus1   = {1'b0, cmd.cmd_arr} + 1'b1;
    cmd_ccr_ext = {1'b0, cmd.cmd_ccr};
    tgt_new     = (cmd_ccr_ext < arr_plus1) ? cmd_ccr_ext : arr_plus1;
  end

  // Next compare value: one step toward tgt, saturating exactly at tgt
  always_comb begin
    ccr_ext  = {1'b0, counter_ccr_q};
    step_ext = {1'b0, step_q};
    ramp_sum = ccr_ext + step_ext;
    ramp_gap = ccr_ext - tgt_q;
    ccr_next = tgt_q;
    if (step_q != '0) begin
      if (ccr_ext < tgt_q) begin
        ccr_next = (ramp_sum >= tgt_q) ? tgt_q : ramp_sum;
      end else if (ccr_ext > tgt_q) begin
        // gap is only meaningful here, where ccr is above the target
        ccr_next = (step_ext >= ramp_gap) ? tgt_q : (ccr_ext - step_ext);
      end
    end
  end

  // Sequencing: next-state and next-output computation
  always_comb begin
    state_d       = state_q;
    cnt_en_d      = cnt_en_q;
    counter_arr_d = counter_arr_q;
    counter_ccr_d = counter_ccr_q;
    arr_pend_d    = arr_pend_q;
    tgt_d         = tgt_q;
    step_d        = step_q;
    hold_d        = hold_q;
    hold_cnt_d    = hold_cnt_q;
    done_d        = 1'b0;

    if (!cnt_en_q || pend) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_stop) begin
            done_d = 1'b1;
          end else begin
            counter_arr_d = cmd.cmd_arr;
            counter_ccr_d = '0;
            cnt_en_d      = 1'b1;
            arr_pend_d    = cmd.cmd_arr;
            tgt_d         = tgt_new;
            step_d        = cmd.cmd_step;
            hold_d        = cmd.cmd_hold;
            hold_cnt_d    = '0;
            state_d       = RAMP;
          end
        end
      end

      RAMP: begin
        if (pend) begin
          counter_arr_d = arr_pend_q;
          if (hold_cnt_q == hold_q) begin
            hold_cnt_d    = '0;
            counter_ccr_d = ccr_next[CNT_W-1:0];
            if (ccr_next == tgt_q) begin
              state_d = STEADY;
              done_d  = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      STEADY: begin
        if (accept) begin
          if (cmd.cmd_stop) begin
            state_d = STOP_WAIT;
          end else begin
            // new arr is only staged; RAMP applies it at the next boundary
            arr_pend_d = cmd.cmd_arr;
            tgt_d      = tgt_new;
            step_d     = cmd.cmd_step;
            hold_d     = cmd.cmd_hold;
            hold_cnt_d = '0;
            state_d    = RAMP;
          end
        end
      end

      STOP_WAIT: begin
        if (pend) begin
          cnt_en_d      = 1'b0;
          counter_ccr_d = '0;
          state_d       = IDLE;
          done_d        = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE) || (state_d == STEADY);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state_q       <= IDLE;
      cnt_en_q      <= 1'b0;
      counter_arr_q <= '0;
      counter_ccr_q <= '0;
      period_cnt_q  <= '0;
      arr_pend_q    <= '0;
      tgt_q         <= '0;
      step_q        <= '0;
      hold_q        <= '0;
      hold_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_en_q      <= cnt_en_d;
      counter_arr_q <= counter_arr_d;
      counter_ccr_q <= counter_ccr_d;
      period_cnt_q  <= period_cnt_d;
      arr_pend_q    <= arr_pend_d;
      tgt_q         <= tgt_d;
      step_q        <= step_d;
      hold_q        <= hold_d;
      hold_cnt_q    <= hold_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramp up/down, hold spacing, deferred
// period change, clamp, stop sequencing and mid-ramp reset.
module tb_pwm_ramp_ctrl;

  logic        Clk50M = 1'b0;
  logic        Rst;
  logic        cnt_en;
  logic [31:0] counter_arr;
  logic [31:0] counter_ccr;
  logic        period_end;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int n;

  pwm_ramp_ctrl_if #(.CNT_W(32), .HOLD_W(16)) cmd_if ();

  pwm_ramp_ctrl #(.CNT_W(32), .HOLD_W(16)) dut (
    .Clk50M      (Clk50M),
    .Rst         (Rst),
    .cmd         (cmd_if),
    .cnt_en      (cnt_en),
    .counter_arr (counter_arr),
    .counter_ccr (counter_ccr),
    .period_end  (period_end),
    .busy        (busy),
    .done        (done)
  );

  always #10 Clk50M = ~Clk50M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic stop, input logic [31:0] arr, input logic [31:0] ccr,
                      input logic [31:0] step, input logic [15:0] hold);
    chk("ready_before_send", 64'(cmd_if.cmd_ready), 64'd1);
    cmd_if.cmd_stop  = stop;
    cmd_if.cmd_arr   = arr;
    cmd_if.cmd_ccr   = ccr;
    cmd_if.cmd_step  = step;
    cmd_if.cmd_hold  = hold;
    cmd_if.cmd_valid = 1'b1;
    @(posedge Clk50M);
    @(negedge Clk50M);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Negedges until period_end is seen (bounded)
  task automatic wait_pe(output int cnt, input int limit);
    cnt = 0;
    while (!period_end && cnt < limit) begin
      @(negedge Clk50M);
      cnt++;
    end
  endtask

  // Negedges until counter_ccr departs from its current value (bounded)
  task automatic wait_ccr_change(output int cnt, input int limit);
    logic [31:0] start;
    start = counter_ccr;
    cnt = 0;
    while (counter_ccr == start && cnt < limit) begin
      @(negedge Clk50M);
      cnt++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt_en"}, 64'(cnt_en), 64'd0);
    chk({tag, "_arr"},    64'(counter_arr), 64'd0);
    chk({tag, "_ccr"},    64'(counter_ccr), 64'd0);
    chk({tag, "_ready"},  64'(cmd_if.cmd_ready), 64'd1);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_pe"},     64'(period_end), 64'd0);
  endtask

  initial begin
    Rst              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_stop  = 1'b0;
    cmd_if.cmd_arr   = '0;
    cmd_if.cmd_ccr   = '0;
    cmd_if.cmd_step  = '0;
    cmd_if.cmd_hold  = '0;
    repeat (2) @(posedge Clk50M);
    @(negedge Clk50M);
    chk_reset_outputs("reset");
    Rst = 1'b0;
    @(negedge Clk50M);

    // Ramp up 0 -> 400 in steps of 100, one step per 1000-cycle period
    send(1'b0, 32'd999, 32'd400, 32'd100, 16'd0);
    chk("start_cnt_en", 64'(cnt_en), 64'd1);
    chk("start_arr",    64'(counter_arr), 64'd999);
    chk("start_ccr",    64'(counter_ccr), 64'd0);
    chk("start_busy",   64'(busy), 64'd1);
    chk("start_ready",  64'(cmd_if.cmd_ready), 64'd0);
    for (int unsigned k = 1; k <= 4; k++) begin
      wait_pe(n, 2000);
      chk("up_pe_spacing", 64'(n), 64'd999);
      chk("up_ccr_before", 64'(counter_ccr), 64'(100 * (k - 1)));
      @(negedge Clk50M);
      chk("up_ccr_after", 64'(counter_ccr), 64'(100 * k));
      chk("up_done", 64'(done), (k == 4) ? 64'd1 : 64'd0);
    end
    chk("steady_ready", 64'(cmd_if.cmd_ready), 64'd1);
    chk("steady_busy",  64'(busy), 64'd1);
    @(negedge Clk50M);
    chk("done_one_cycle", 64'(done), 64'd0);

    // Ramp down 400 -> 250 -> 100, step 150, no underflow
    send(1'b0, 32'd999, 32'd100, 32'd150, 16'd0);
    chk("down_ready", 64'(cmd_if.cmd_ready), 64'd0);
    chk("down_ccr_held", 64'(counter_ccr), 64'd400);
    wait_pe(n, 2000);
    chk("down_pe1", 64'(n), 64'd997);
    @(negedge Clk50M);
    chk("down_ccr1", 64'(counter_ccr), 64'd250);
    chk("down_done1", 64'(done), 64'd0);
    wait_pe(n, 2000);
    @(negedge Clk50M);
    chk("down_ccr2", 64'(counter_ccr), 64'd100);
    chk("down_done2", 64'(done), 64'd1);

    // Period change issued at period_cnt=300 lands on the next boundary
    repeat (300) @(negedge Clk50M);
    send(1'b0, 32'd499, 32'd100, 32'd0, 16'd0);
    chk("arr_held_early", 64'(counter_arr), 64'd999);
    wait_pe(n, 2000);
    chk("arr_pe_at_999", 64'(n), 64'd698);
    chk("arr_held_at_pe", 64'(counter_arr), 64'd999);
    @(negedge Clk50M);
    chk("arr_applied", 64'(counter_arr), 64'd499);
    chk("arr_ccr_same", 64'(counter_ccr), 64'd100);
    chk("arr_done", 64'(done), 64'd1);
    wait_pe(n, 2000);
    chk("arr_new_spacing", 64'(n), 64'd499);
    @(negedge Clk50M);

    // Clamp: ccr 2000 with arr 999 -> 1000 (100% duty), step 0 jumps
    send(1'b0, 32'd999, 32'd2000, 32'd0, 16'd0);
    wait_pe(n, 2000);
    chk("clamp_pe", 64'(n), 64'd498);
    @(negedge Clk50M);
    chk("clamp_ccr", 64'(counter_ccr), 64'd1000);
    chk("clamp_arr", 64'(counter_arr), 64'd999);
    chk("clamp_done", 64'(done), 64'd1);

    // Stop at period_cnt=300: runs to end of period, then shuts down
    repeat (300) @(negedge Clk50M);
    send(1'b1, 32'd5, 32'd5, 32'd5, 16'd5);
    chk("stop_ready", 64'(cmd_if.cmd_ready), 64'd0);
    chk("stop_busy",  64'(busy), 64'd1);
    wait_pe(n, 2000);
    chk("stop_pe", 64'(n), 64'd698);
    chk("stop_cnt_en_at_pe", 64'(cnt_en), 64'd1);
    @(negedge Clk50M);
    chk("stop_cnt_en", 64'(cnt_en), 64'd0);
    chk("stop_ccr",    64'(counter_ccr), 64'd0);
    chk("stop_arr",    64'(counter_arr), 64'd999);
    chk("stop_busy_0", 64'(busy), 64'd0);
    chk("stop_ready1", 64'(cmd_if.cmd_ready), 64'd1);
    chk("stop_done",   64'(done), 64'd1);
    @(negedge Clk50M);
    chk("stop_done_clr", 64'(done), 64'd0);
    chk("idle_pe",       64'(period_end), 64'd0);

    // Stop while already idle: done pulse only
    send(1'b1, 32'd0, 32'd0, 32'd0, 16'd0);
    chk("idle_stop_done", 64'(done), 64'd1);
    chk("idle_stop_busy", 64'(busy), 64'd0);
    chk("idle_stop_en",   64'(cnt_en), 64'd0);
    @(negedge Clk50M);
    chk("idle_stop_done_clr", 64'(done), 64'd0);

    // Hold=2 with arr 499: a step every 3rd boundary, 1500 cycles apart
    send(1'b0, 32'd499, 32'd250, 32'd125, 16'd2);
    wait_ccr_change(n, 4000);
    chk("hold_gap1", 64'(n), 64'd1500);
    chk("hold_ccr1", 64'(counter_ccr), 64'd125);
    wait_ccr_change(n, 4000);
    chk("hold_gap2", 64'(n), 64'd1500);
    chk("hold_ccr2", 64'(counter_ccr), 64'd250);
    chk("hold_done", 64'(done), 64'd1);

    // Reset in the middle of a ramp
    send(1'b0, 32'd999, 32'd500, 32'd100, 16'd0);
    wait_pe(n, 2000);
    chk("rr_pe", 64'(n), 64'd498);
    @(negedge Clk50M);
    chk("rr_arr", 64'(counter_arr), 64'd999);
    chk("rr_ccr", 64'(counter_ccr), 64'd350);
    repeat (100) @(negedge Clk50M);
    Rst = 1'b1;
    @(posedge Clk50M);
    @(negedge Clk50M);
    chk_reset_outputs("midramp_rst");
    Rst = 1'b0;
    repeat (5) @(negedge Clk50M);
    chk("post_rst_en",   64'(cnt_en), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
